// File: rtl/block_memory_ctrl_if.sv
// Request/response bus between the write-back data cache and the block memory controller.
interface block_memory_ctrl_if #(
   parameter int WORD_SIZE  = 32,
   parameter int BLOCK_SIZE = 16
);
   logic                             req_valid;
   logic                             req_ready;
   logic                             req_write;
   logic [WORD_SIZE-1:0]             req_addr;
   logic [WORD_SIZE*BLOCK_SIZE-1:0]  req_block;
   logic                             resp_valid;
   logic [WORD_SIZE*BLOCK_SIZE-1:0]  resp_block;
   logic                             resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_block,
      input  req_ready, resp_valid, resp_block, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_block,
      output req_ready, resp_valid, resp_block, resp_err
   );
endinterface

// File: rtl/block_memory_ctrl.sv
// Backing-store controller: whole-block reads and write-backs with a fixed access latency
// and a one-cycle response pulse. Owns the block-organised data array.
module block_memory_ctrl #(
   parameter int WORD_SIZE  = 32,
   parameter int BLOCK_SIZE = 16,
   parameter int MEM_BLOCKS = 1024,
   parameter int LATENCY    = 4
) (
   input  logic               clk,
   input  logic               reset,
   block_memory_ctrl_if.slave bus
);
   localparam int BLOCK_W     = WORD_SIZE * BLOCK_SIZE;
   localparam int OFFSET_BITS = $clog2(BLOCK_SIZE);
   localparam int ADDR_W      = (MEM_BLOCKS > 1) ? $clog2(MEM_BLOCKS) : 1;
   localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t               state;
   logic [7:0]           count;
   logic                 write_q;
   logic [WORD_SIZE-1:0] index_q;
   logic [BLOCK_W-1:0]   block_q;
   logic                 ready_q;
   logic                 valid_q;
   logic                 err_q;
   logic [BLOCK_W-1:0]   resp_q;
   logic                 in_range;
   logic                 commit;

   // Array contents survive reset; only the power-on value is zero.
   logic [BLOCK_W-1:0]   mem [MEM_BLOCKS] = '{default: '0};

   assign in_range = (index_q < WORD_SIZE'(MEM_BLOCKS));
   // A reset on the access edge must suppress the write so an aborted write-back never lands.
   assign commit   = (state == BUSY) && (count == 8'd0) && write_q && in_range && !reset;

   assign bus.req_ready  = ready_q;
   assign bus.resp_valid = valid_q;
   assign bus.resp_block = resp_q;
   assign bus.resp_err   = err_q;

   always_ff @(posedge clk) begin
      if (commit) begin
         mem[index_q[ADDR_W-1:0]] <= block_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         count   <= 8'd0;
         write_q <= 1'b0;
         index_q <= '0;
         block_q <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         resp_q  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  write_q <= bus.req_write;
                  index_q <= bus.req_addr >> OFFSET_BITS;
                  block_q <= bus.req_block;
                  count   <= LOAD_COUNT;
                  ready_q <= 1'b0;
                  state   <= BUSY;
               end
            end
            BUSY: begin
               if (count == 8'd0) begin
                  valid_q <= 1'b1;
                  state   <= RESP;
                  if (!in_range) begin
                     err_q  <= 1'b1;
                     resp_q <= '0;
                  end else begin
                     err_q  <= 1'b0;
                     resp_q <= write_q ? block_q : mem[index_q[ADDR_W-1:0]];
                  end
               end else begin
                  count <= count - 8'd1;
               end
            end
            RESP: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               valid_q <= 1'b0;
               ready_q <= 1'b1;
               state   <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_block_memory_ctrl.sv
// Scoreboard bench for block_memory_ctrl: one instance at LATENCY=4, one at LATENCY=1.
module tb_block_memory_ctrl;
   localparam int WS = 32;
   localparam int BS = 16;
   localparam int BW = WS * BS;

   typedef struct {
      logic [BW-1:0] blk;
      logic          err;
      string         tag;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   exp_t expA[$];
   exp_t expB[$];

   block_memory_ctrl_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) busA ();
   block_memory_ctrl_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS)) busB ();

   block_memory_ctrl #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .MEM_BLOCKS(1024), .LATENCY(4)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA)
   );

   block_memory_ctrl #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .MEM_BLOCKS(1024), .LATENCY(1)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Word 0 sits in the most significant word, matching the cache line layout.
   function automatic logic [BW-1:0] makeBlock(input logic [31:0] base);
      logic [BW-1:0] b;
      b = '0;
      for (int i = 0; i < BS; i++) b[BW-1-32*i -: 32] = base + 32'(i);
      return b;
   endfunction

   task automatic checkOutput(input string name, input logic [BW-1:0] actual, input logic [BW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
      end
   endtask

   task automatic monitorA();
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (busA.resp_valid) begin
            if (expA.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_resp_A: actual=resp_valid required=no response");
            end else begin
               e = expA.pop_front();
               checkOutput({e.tag, "_block"}, busA.resp_block, e.blk);
               checkOutput({e.tag, "_err"}, BW'(busA.resp_err), BW'(e.err));
            end
         end
      end
   endtask

   task automatic monitorB();
      exp_t   e;
      longint lastT;
      lastT = -1;
      forever begin
         @(posedge clk);
         #1;
         if (busB.resp_valid) begin
            if (lastT >= 0) checkOutput("b2b_spacing", BW'($time - lastT), BW'(30));
            lastT = $time;
            if (expB.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_resp_B: actual=resp_valid required=no response");
            end else begin
               e = expB.pop_front();
               checkOutput({e.tag, "_block"}, busB.resp_block, e.blk);
               checkOutput({e.tag, "_err"}, BW'(busB.resp_err), BW'(e.err));
            end
         end
      end
   endtask

   // Returns #1 after the accepting edge, with req_valid already dropped.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [BW-1:0] blk,
                                input logic [BW-1:0] expBlk, input logic expErr, input string tag,
                                input bit pushExp);
      exp_t e;
      int   waited;
      waited = 0;
      @(negedge clk);
      while (!busA.req_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!busA.req_ready) begin
         checks++;
         failures++;
         $display("[TB] FAIL %s_accept: actual=req_ready 0 required=req_ready 1", tag);
         return;
      end
      busA.req_valid = 1'b1;
      busA.req_write = wr;
      busA.req_addr  = addr;
      busA.req_block = blk;
      @(posedge clk);
      if (pushExp) begin
         e.blk = expBlk;
         e.err = expErr;
         e.tag = tag;
         expA.push_back(e);
      end
      #1;
      busA.req_valid = 1'b0;
   endtask

   task automatic waitDrain(input bit isB);
      int waited;
      waited = 0;
      while ((isB ? expB.size() : expA.size()) != 0 && waited < 60) begin
         @(posedge clk);
         waited++;
      end
      @(posedge clk);
      #2;
      checkOutput(isB ? "drain_B" : "drain_A", BW'(isB ? expB.size() : expA.size()), BW'(0));
   endtask

   initial begin
      logic [BW-1:0] idxBlk;
      logic [BW-1:0] p1;
      logic [BW-1:0] p2;
      logic [BW-1:0] lastWr;
      logic [BW-1:0] cur;
      checks   = 0;
      failures = 0;
      idxBlk   = makeBlock(32'h0000_0000);
      p1       = makeBlock(32'hA5A5_0000);
      p2       = makeBlock(32'h5A5A_0000);
      lastWr   = '0;
      busA.req_valid = 1'b0; busA.req_write = 1'b0; busA.req_addr = '0; busA.req_block = '0;
      busB.req_valid = 1'b0; busB.req_write = 1'b0; busB.req_addr = '0; busB.req_block = '0;
      reset = 1'b1;
      fork
         monitorA();
         monitorB();
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         checkOutput("idle_ready", BW'(busA.req_ready), BW'(1));
         checkOutput("idle_valid", BW'(busA.resp_valid), BW'(0));
         checkOutput("idle_block", busA.resp_block, '0);
         checkOutput("idle_err", BW'(busA.resp_err), BW'(0));
      end

      $display("[TB] read of fresh array with latency check");
      applyStimulus(1'b0, 32'h0000_0050, '0, '0, 1'b0, "fresh_read", 1'b1);
      for (int k = 0; k <= 5; k++) begin
         checkOutput($sformatf("lat_ready_%0d", k), BW'(busA.req_ready), BW'(k == 5));
         checkOutput($sformatf("lat_valid_%0d", k), BW'(busA.resp_valid), BW'(k == 4));
         if (k < 5) begin
            @(posedge clk);
            #1;
         end
      end
      waitDrain(1'b0);

      $display("[TB] write then read with offset bits set");
      applyStimulus(1'b1, 32'h0000_0020, idxBlk, idxBlk, 1'b0, "wr_idx2", 1'b1);
      applyStimulus(1'b0, 32'h0000_002F, '0, idxBlk, 1'b0, "rd_idx2", 1'b1);
      waitDrain(1'b0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("hold_block", busA.resp_block, idxBlk);

      $display("[TB] out-of-range accesses and last valid block");
      applyStimulus(1'b0, 32'h0000_4000, '0, '0, 1'b1, "oor_read", 1'b1);
      applyStimulus(1'b1, 32'h0000_4000, p2, '0, 1'b1, "oor_write", 1'b1);
      applyStimulus(1'b0, 32'h0000_0000, '0, '0, 1'b0, "rd_idx0", 1'b1);
      applyStimulus(1'b1, 32'h0000_3FF0, p2, p2, 1'b0, "wr_idx1023", 1'b1);
      applyStimulus(1'b0, 32'h0000_3FFF, '0, p2, 1'b0, "rd_idx1023", 1'b1);
      waitDrain(1'b0);

      $display("[TB] reset during a busy write");
      applyStimulus(1'b1, 32'h0000_0070, p1, p1, 1'b0, "wr_idx7", 1'b1);
      applyStimulus(1'b0, 32'h0000_0070, '0, p1, 1'b0, "rd_idx7", 1'b1);
      waitDrain(1'b0);
      applyStimulus(1'b1, 32'h0000_0075, p2, '0, 1'b0, "abort_wr", 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_ready", BW'(busA.req_ready), BW'(1));
      checkOutput("abort_valid", BW'(busA.resp_valid), BW'(0));
      checkOutput("abort_block", busA.resp_block, '0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk);
         #1;
         checkOutput("abort_no_resp", BW'(busA.resp_valid), BW'(0));
      end
      applyStimulus(1'b0, 32'h0000_0070, '0, p1, 1'b0, "rd_idx7_after", 1'b1);
      waitDrain(1'b0);

      $display("[TB] latency 1, request held valid, alternating write/read to index 3");
      busB.req_addr = 32'h0000_0030;
      for (int t = 0; t < 6; t++) begin
         exp_t e;
         int   waited;
         waited = 0;
         @(negedge clk);
         while (!busB.req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
         end
         if (!busB.req_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL b2b_accept_%0d: actual=req_ready 0 required=req_ready 1", t);
         end else begin
            cur = makeBlock(32'hB000_0000 + 32'(t * 16));
            busB.req_valid = 1'b1;
            busB.req_write = (t % 2 == 0);
            busB.req_block = cur;
            if (t % 2 == 0) lastWr = cur;
            @(posedge clk);
            e.blk = lastWr;
            e.err = 1'b0;
            e.tag = $sformatf("b2b_%0d", t);
            expB.push_back(e);
         end
      end
      #1;
      busB.req_valid = 1'b0;
      waitDrain(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end
endmodule
